alu_op_sequencer: RTL

//  Initiator that drives the 8-bit combinational ALU: accepts one command+operand per handshake,

---
 rtl/alu_op_sequencer.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one command at a time to an external 8-bit combinational ALU,
// holds its inputs for ALU_WAIT cycles, captures the result into the accumulator and flags,
// and returns result/flags on a valid/ready response channel.
module alu_op_sequencer #(
    parameter int unsigned ALU_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_cmd,
    input  logic [7:0] req_operand,
    output logic [7:0] alu_register,
    output logic [7:0] alu_memory,
    output logic [4:0] alu_op_sel,
    output logic       alu_ci,
    output logic       alu_si,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [2:0] rsp_flags,
    output logic       rsp_err,
    output logic [7:0] acc
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned SEL_W  = 5;
    localparam int unsigned CNT_W  = 4;

    // Last hold-counter value; capture happens on the edge that ends this cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_WAIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [CMD_W-1:0] CMD_ORA = 4'd0;
    localparam logic [CMD_W-1:0] CMD_AND = 4'd1;
    localparam logic [CMD_W-1:0] CMD_EOR = 4'd2;
    localparam logic [CMD_W-1:0] CMD_ADC = 4'd3;
    localparam logic [CMD_W-1:0] CMD_INC = 4'd4;
    localparam logic [CMD_W-1:0] CMD_DEC = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SBC = 4'd6;
    localparam logic [CMD_W-1:0] CMD_CMP = 4'd7;
    localparam logic [CMD_W-1:0] CMD_TRB = 4'd8;
    localparam logic [CMD_W-1:0] CMD_LDA = 4'd9;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic              n_q, n_d;
    logic              req_ready_q, req_ready_d;
    logic [DATA_W-1:0] alu_register_q, alu_register_d;
    logic [DATA_W-1:0] alu_memory_q, alu_memory_d;
    logic [SEL_W-1:0]  alu_op_sel_q, alu_op_sel_d;
    logic              alu_ci_q, alu_ci_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [2:0]        rsp_flags_q, rsp_flags_d;
    logic              rsp_err_q, rsp_err_d;

    logic [2:0]        issue_sel;
    logic              issue_ci;

    logic [DATA_W-1:0] cap_result;
    logic              cap_err;
    logic              cap_wr_a;
    logic              cap_upd_c;
    logic              cap_c;
    logic              cap_z;
    logic              cap_n;

    // Map an incoming command to ALU select and carry-in (LDA/illegal leave the ALU at 0).
    always_comb begin
        issue_sel = 3'b000;
        issue_ci  = 1'b0;
        case (req_cmd)
            CMD_ORA: issue_sel = 3'b000;
            CMD_AND: issue_sel = 3'b001;
            CMD_EOR: issue_sel = 3'b010;
            CMD_ADC: begin
                issue_sel = 3'b011;
                issue_ci  = c_q;
            end
            CMD_INC: begin
                issue_sel = 3'b100;
                issue_ci  = 1'b1;
            end
            CMD_DEC: issue_sel = 3'b101;
            CMD_SBC: begin
                issue_sel = 3'b110;
                issue_ci  = c_q;
            end
            CMD_CMP: begin
                issue_sel = 3'b110;
                issue_ci  = 1'b1;
            end
            CMD_TRB: issue_sel = 3'b111;
            default: begin
                issue_sel = 3'b000;
                issue_ci  = 1'b0;
            end
        endcase
    end

    // Decide what the latched command does with the sampled ALU result.
    always_comb begin
        cap_result = '0;
        cap_err    = 1'b0;
        cap_wr_a   = 1'b0;
        cap_upd_c  = 1'b0;
        case (cmd_q)
            CMD_ORA, CMD_AND, CMD_EOR, CMD_INC, CMD_DEC: begin
                cap_result = alu_out;
                cap_wr_a   = 1'b1;
            end
            CMD_ADC, CMD_SBC: begin
                cap_result = alu_out;
                cap_wr_a   = 1'b1;
                cap_upd_c  = 1'b1;
            end
            CMD_CMP: begin
                cap_result = alu_out;
                cap_upd_c  = 1'b1;
            end
            CMD_TRB: cap_result = alu_out;
            CMD_LDA: begin
                cap_result = alu_memory_q;
                cap_wr_a   = 1'b1;
            end
            default: cap_err = 1'b1;
        endcase
        cap_c = cap_upd_c ? alu_co : c_q;
        cap_z = cap_err ? z_q : (cap_result == '0);
        cap_n = cap_err ? n_q : cap_result[DATA_W-1];
    end

    // Next-state and registered-output logic for the command sequencer.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cmd_d          = cmd_q;
        a_d            = a_q;
        c_d            = c_q;
        z_d            = z_q;
        n_d            = n_q;
        alu_register_d = alu_register_q;
        alu_memory_d   = alu_memory_q;
        alu_op_sel_d   = alu_op_sel_q;
        alu_ci_d       = alu_ci_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_flags_d    = rsp_flags_q;
        rsp_err_d      = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cmd_d          = req_cmd;
                    alu_register_d = a_q;
                    alu_memory_d   = req_operand;
                    alu_op_sel_d   = {2'b00, issue_sel};
                    alu_ci_d       = issue_ci;
                    cnt_d          = '0;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    if (cap_wr_a) begin
                        a_d = cap_result;
                    end
                    c_d          = cap_c;
                    z_d          = cap_z;
                    n_d          = cap_n;
                    rsp_result_d = cap_result;
                    rsp_flags_d  = {cap_n, cap_z, cap_c};
                    rsp_err_d    = cap_err;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            cmd_q          <= '0;
            a_q            <= '0;
            c_q            <= 1'b0;
            z_q            <= 1'b0;
            n_q            <= 1'b0;
            req_ready_q    <= 1'b0;
            alu_register_q <= '0;
            alu_memory_q   <= '0;
            alu_op_sel_q   <= '0;
            alu_ci_q       <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_flags_q    <= '0;
            rsp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cmd_q          <= cmd_d;
            a_q            <= a_d;
            c_q            <= c_d;
            z_q            <= z_d;
            n_q            <= n_d;
            req_ready_q    <= req_ready_d;
            alu_register_q <= alu_register_d;
            alu_memory_q   <= alu_memory_d;
            alu_op_sel_q   <= alu_op_sel_d;
            alu_ci_q       <= alu_ci_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_flags_q    <= rsp_flags_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign alu_register = alu_register_q;
    assign alu_memory   = alu_memory_q;
    assign alu_op_sel   = alu_op_sel_q;
    assign alu_ci       = alu_ci_q;
    assign alu_si       = 1'b0;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_flags    = rsp_flags_q;
    assign rsp_err      = rsp_err_q;
    assign acc          = a_q;

endmodule
